// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access widths, FSM states, size helper.
// LSU_MISALIGN_EN adds the second-word read state used by split misaligned loads.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

`ifdef LSU_MISALIGN_EN
  typedef enum logic [2:0] {IDLE, ST, RD0, RD1, RESP} lsu_state_e;
`else
  typedef enum logic [2:0] {IDLE, ST, RD0, RESP} lsu_state_e;
`endif

  // Access size in bytes; the unsigned variants share the low funct3 bits with the signed ones.
  function automatic logic [2:0] access_size(input logic [2:0] width);
    case (width[1:0])
      2'b00:   access_size = 3'd1;
      2'b01:   access_size = 3'd2;
      default: access_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the captured word pair by the byte offset, extracts the
// access-sized field and sign- or zero-extends it to 32 bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  input  logic [1:0]  offset,
  input  logic [2:0]  width,
  output logic [31:0] rdata
);

  logic [31:0] low;

  // NOTE: every output of an always_comb gets a default before any branch so no latch is inferred.
  always_comb begin
    low   = 32'({word1, word0} >> {offset, 3'b000});
    rdata = low;
    case (width)
      F3_B:    rdata = {{24{low[7]}}, low[7:0]};
      F3_H:    rdata = {{16{low[15]}}, low[15:0]};
      F3_BU:   rdata = {24'd0, low[7:0]};
      F3_HU:   rdata = {16'd0, low[15:0]};
      default: rdata = low;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one request at a time, sequences word accesses to a
// combinational-read memory and returns one response pulse. LSU_MISALIGN_EN enables misaligned loads.
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_width,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_width,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, wdata_q, word0_q, word1, load_data;
  logic [2:0]  width_q, req_size;
  logic        we_q, err_q, accept, legal_width, req_misaligned, req_err, split;

  assign accept = (state_q == IDLE) && req_valid;

  always_comb begin
    req_size       = access_size(req_width);
    legal_width    = (req_width == F3_B)  || (req_width == F3_H)  || (req_width == F3_W) ||
                     (req_width == F3_BU) || (req_width == F3_HU);
    req_misaligned = ((req_size == 3'd2) && req_addr[0]) ||
                     ((req_size == 3'd4) && (req_addr[1:0] != 2'b00));
    req_err        = !legal_width || (req_we && (req_width[2] || req_misaligned));
`ifndef LSU_MISALIGN_EN
    req_err        = req_err || (!req_we && req_misaligned);
`endif
  end

`ifdef LSU_MISALIGN_EN
  logic [31:0] word1_q;
  // The access runs past the aligned word when offset + size exceeds four bytes.
  assign split = ({2'b00, addr_q[1:0]} + {1'b0, access_size(width_q)}) > 4'd4;
  assign word1 = word1_q;
`else
  assign split = 1'b0;
  assign word1 = 32'd0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      word0_q <= '0;
`ifdef LSU_MISALIGN_EN
      word1_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        width_q <= req_width;
        we_q    <= req_we;
        err_q   <= req_err;
      end
      if (state_q == RD0) word0_q <= mem_rdata;
`ifdef LSU_MISALIGN_EN
      if (state_q == RD1) word1_q <= mem_rdata;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_width  = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_err ? RESP : (req_we ? ST : RD0);
      end
      ST: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_width = width_q;
        mem_wdata = wdata_q;
        state_d   = RESP;
      end
      RD0: begin
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_width = F3_W;
`ifdef LSU_MISALIGN_EN
        state_d   = split ? RD1 : RESP;
`else
        state_d   = RESP;
`endif
      end
`ifdef LSU_MISALIGN_EN
      RD1: begin
        // Second word wraps modulo 2^32 through the natural 32-bit add.
        mem_addr  = {addr_q[31:2], 2'b00} + 32'd4;
        mem_width = F3_W;
        state_d   = RESP;
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  lsu_load_align u_align (
    .word0  (word0_q),
    .word1  (word1),
    .offset (addr_q[1:0]),
    .width  (width_q),
    .rdata  (load_data)
  );

  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q && !we_q) ? load_data : 32'd0;

  logic unused_split;
  assign unused_split = split;

endmodule
